// File: rtl/magic_pkg.sv
// Shared types and width constants for the MAGIC NOR/INV executor.
// Instruction word layout is {op, dst, src_a, src_b}.
package magic_pkg;
   localparam int N_CELLS    = 64;
   localparam int N_IN       = 7;
   localparam int N_OUT      = 8;
   localparam int PROG_DEPTH = 64;
   localparam int CW         = $clog2(N_CELLS);
   localparam int PAW        = $clog2(PROG_DEPTH);
   localparam int OW         = $clog2(N_OUT);
   localparam int IW         = 2 + 3 * CW;

   typedef enum logic [1:0] {
      OP_END  = 2'b00,
      OP_NOR2 = 2'b01,
      OP_INV1 = 2'b10,
      OP_OUT  = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_DECODE,
      S_EVAL,
      S_DONE
   } state_e;

   typedef struct packed {
      op_e           op;
      logic [CW-1:0] dst;
      logic [CW-1:0] src_a;
      logic [CW-1:0] src_b;
   } instr_t;

   function automatic logic cell_ok(input logic [CW-1:0] idx);
      return int'(idx) < N_CELLS;
   endfunction
endpackage

// File: rtl/magic_cell_array.sv
// Bit-cell row emulating one crossbar row: two read ports, one write
// port, and a bulk load that places inputs and clears the rest.
module magic_cell_array
   import magic_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ld_en,
   input  logic [N_IN-1:0] ld_vec,
   input  logic [CW-1:0]   ra_a,
   input  logic [CW-1:0]   ra_b,
   output logic            rd_a,
   output logic            rd_b,
   input  logic            we,
   input  logic [CW-1:0]   wa,
   input  logic            wd
);
   logic [N_CELLS-1:0] cells_q;
   logic [N_CELLS-1:0] cells_d;

   always_comb begin
      cells_d = cells_q;
      if (ld_en) begin
         cells_d = {{(N_CELLS-N_IN){1'b0}}, ld_vec};
      end else if (we && cell_ok(wa)) begin
         cells_d[wa] = wd;
      end
   end

   // Out-of-range reads see a constant 0
   assign rd_a = cell_ok(ra_a) ? cells_q[ra_a] : 1'b0;
   assign rd_b = cell_ok(ra_b) ? cells_q[ra_b] : 1'b0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cells_q <= '0;
      end else begin
         cells_q <= cells_d;
      end
   end
endmodule

// File: rtl/magic_nor_exec.sv
// Sequential MAGIC executor: runs a NOR/INV microprogram gate by gate,
// two cycles per gate (INIT to 1, then EVAL), on a bit-cell row.
module magic_nor_exec
   import magic_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             prog_we,
   input  logic [PAW-1:0]   prog_addr,
   input  logic [IW-1:0]    prog_data,
   input  logic             start,
   input  logic [N_IN-1:0]  in_vec,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [N_OUT-1:0] result,
   output logic [15:0]      exec_cycles
);
   state_e           state_q, state_d;
   logic [PAW-1:0]   pc_q, pc_d;
   logic [N_IN-1:0]  in_q, in_d;
   logic             err_q, err_d;
   logic [N_OUT-1:0] res_q, res_d;
   logic [15:0]      cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   instr_t mem_q [PROG_DEPTH];
   instr_t ins;
   logic   mem_we;

   logic          c_ld, c_we, c_wd;
   logic          rd_a, rd_b;
   logic          last;
   logic          gate_bad;
   logic [15:0]   cnt_inc;

   assign ins     = mem_q[pc_q];
   assign mem_we  = prog_we && (state_q == S_IDLE);
   assign last    = (pc_q == PAW'(PROG_DEPTH - 1));
   assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

   // Aliased operands still execute; they just flag the run
   assign gate_bad = !cell_ok(ins.dst) || !cell_ok(ins.src_a)
                  || (ins.dst == ins.src_a)
                  || ((ins.op == OP_NOR2)
                      && (!cell_ok(ins.src_b) || ins.dst == ins.src_b));

   magic_cell_array u_cells (
      .clk    (clk),
      .rst_n  (rst_n),
      .ld_en  (c_ld),
      .ld_vec (in_q),
      .ra_a   (ins.src_a),
      .ra_b   (ins.src_b),
      .rd_a   (rd_a),
      .rd_b   (rd_b),
      .we     (c_we),
      .wa     (ins.dst),
      .wd     (c_wd)
   );

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      in_d    = in_q;
      err_d   = err_q;
      res_d   = res_q;
      cnt_d   = cnt_q;
      c_ld    = 1'b0;
      c_we    = 1'b0;
      c_wd    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               in_d    = in_vec;
               err_d   = 1'b0;
               res_d   = '0;
               cnt_d   = '0;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            c_ld    = 1'b1;
            pc_d    = '0;
            cnt_d   = cnt_inc;
            state_d = S_DECODE;
         end
         S_DECODE: begin
            cnt_d = cnt_inc;
            unique case (ins.op)
               OP_NOR2, OP_INV1: begin
                  c_we    = 1'b1;
                  c_wd    = 1'b1;
                  err_d   = err_q | gate_bad;
                  state_d = S_EVAL;
               end
               OP_OUT: begin
                  res_d[ins.dst[OW-1:0]] = rd_a;
                  if (!cell_ok(ins.src_a)) err_d = 1'b1;
                  if (last) begin
                     err_d   = 1'b1;
                     state_d = S_DONE;
                  end else begin
                     pc_d = pc_q + 1'b1;
                  end
               end
               default: state_d = S_DONE;
            endcase
         end
         S_EVAL: begin
            cnt_d = cnt_inc;
            c_we  = 1'b1;
            c_wd  = (ins.op == OP_NOR2) ? ~(rd_a | rd_b) : ~rd_a;
            if (last) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               pc_d    = pc_q + 1'b1;
               state_d = S_DECODE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         pc_q    <= '0;
         in_q    <= '0;
         err_q   <= 1'b0;
         res_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         in_q    <= in_d;
         err_q   <= err_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < PROG_DEPTH; i++) mem_q[i] <= '0;
      end else if (mem_we) begin
         mem_q[prog_addr] <= instr_t'(prog_data);
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign err         = err_q;
   assign result      = res_q;
   assign exec_cycles = cnt_q;
endmodule

// File: tb/tb_magic_nor_exec.sv
// Randomized self-checking bench for magic_nor_exec against an
// instruction-level interpreter of the program image.
module tb_magic_nor_exec;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        prog_we;
   logic [5:0]  prog_addr;
   logic [19:0] prog_data;
   logic        start;
   logic [6:0]  in_vec;
   logic        busy, done, err;
   logic [7:0]  result;
   logic [15:0] exec_cycles;

   logic [19:0] tb_mem [64];
   int n_chk = 0;
   int n_fail = 0;

   magic_nor_exec dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .prog_we     (prog_we),
      .prog_addr   (prog_addr),
      .prog_data   (prog_data),
      .start       (start),
      .in_vec      (in_vec),
      .busy        (busy),
      .done        (done),
      .err         (err),
      .result      (result),
      .exec_cycles (exec_cycles)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic logic [19:0] mk(input logic [1:0] op, input int d,
                                      input int a, input int b);
      return {op, d[5:0], a[5:0], b[5:0]};
   endfunction

   // Interpreter: walks the program image one instruction at a time
   task automatic model(input logic [6:0] v, output logic [7:0] r,
                        output logic e, output int cyc);
      logic [63:0] c;
      logic [19:0] w;
      logic [1:0]  op;
      logic [5:0]  d, a, b;
      int pc;
      bit stop;
      c = '0;
      c[6:0] = v;
      r = '0;
      e = 1'b0;
      cyc = 1;
      pc = 0;
      stop = 0;
      while (!stop) begin
         w = tb_mem[pc];
         op = w[19:18];
         d = w[17:12];
         a = w[11:6];
         b = w[5:0];
         if (op == 2'b00) begin
            cyc += 1;
            stop = 1;
         end else begin
            if (op == 2'b11) begin
               r[d[2:0]] = c[a];
               cyc += 1;
            end else begin
               if (d == a || (op == 2'b01 && d == b)) e = 1'b1;
               c[d] = 1'b1;
               if (op == 2'b01) c[d] = ~(c[a] | c[b]);
               else c[d] = ~c[a];
               cyc += 2;
            end
            if (pc == 63) begin
               e = 1'b1;
               stop = 1;
            end else begin
               pc++;
            end
         end
      end
   endtask

   task automatic wr(input int a, input logic [19:0] d);
      @(negedge clk);
      prog_we = 1'b1;
      prog_addr = a[5:0];
      prog_data = d;
      tb_mem[a] = d;
   endtask

   task automatic load_xor();
      wr(0, mk(2'b01, 7, 0, 1));
      wr(1, mk(2'b01, 8, 0, 7));
      wr(2, mk(2'b01, 9, 1, 7));
      wr(3, mk(2'b01, 10, 8, 9));
      wr(4, mk(2'b10, 11, 10, 0));
      wr(5, mk(2'b11, 0, 11, 0));
      wr(6, 20'h0);
   endtask

   task automatic run(input logic [6:0] v, input bit hz);
      logic [7:0]  er;
      logic        ee;
      logic [19:0] mw;
      int ec, c;
      bit got;
      model(v, er, ee, ec);
      @(negedge clk);
      prog_we = 1'b0;
      start = 1'b1;
      in_vec = v;
      c = 0;
      got = 0;
      while (c < 400 && !got) begin
         @(negedge clk);
         c++;
         chk("busy_during_run", busy, 1);
         if (done) begin
            got = 1;
            start = 1'b0;
            prog_we = 1'b0;
         end else if (hz) begin
            start = 1'($urandom_range(0, 1));
            prog_we = 1'($urandom_range(0, 1));
            prog_addr = 6'($urandom);
            prog_data = 20'($urandom);
            in_vec = 7'($urandom);
         end else begin
            start = 1'b0;
         end
      end
      chk("done_seen", got, 1);
      chk("done_cycle", c, ec + 1);
      chk("result", result, er);
      chk("err", err, ee);
      chk("exec_cycles", exec_cycles, ec);
      @(negedge clk);
      chk("busy_after_done", busy, 0);
      chk("done_one_cycle", done, 0);
      chk("result_held", result, er);
      chk("err_held", err, ee);
      if (hz) begin
         for (int i = 0; i < 64; i++) begin
            mw = dut.mem_q[i];
            chk("mem_unchanged", mw, tb_mem[i]);
         end
      end
   endtask

   initial begin
      logic [7:0]  mr;
      logic        me;
      logic [19:0] mw;
      int mc, len, nz;
      rst_n = 1'b0;
      prog_we = 1'b0;
      prog_addr = '0;
      prog_data = '0;
      start = 1'b0;
      in_vec = '0;
      for (int i = 0; i < 64; i++) tb_mem[i] = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_result", result, 0);
      chk("rst_exec", exec_cycles, 0);
      rst_n = 1'b1;

      model(7'h55, mr, me, mc);
      chk("pin_empty_exec", mc, 2);
      chk("pin_empty_res", mr, 0);
      run(7'h55, 0);

      load_xor();
      for (int x = 0; x < 4; x++) begin
         logic [6:0] v;
         v = {5'($urandom), 2'(x)};
         model(v, mr, me, mc);
         chk("pin_xor_bit", mr[0], v[0] ^ v[1]);
         chk("pin_xor_exec", mc, 13);
         chk("pin_xor_err", me, 0);
         run(v, 0);
      end

      wr(0, mk(2'b01, 7, 7, 0));
      wr(1, mk(2'b11, 0, 7, 0));
      wr(2, 20'h0);
      model(7'h7F, mr, me, mc);
      chk("pin_viol_err", me, 1);
      chk("pin_viol_res", mr, 0);
      run(7'h7F, 0);

      wr(0, mk(2'b11, 3, 0, 0));
      wr(1, mk(2'b11, 3, 1, 0));
      wr(2, 20'h0);
      model(7'h01, mr, me, mc);
      chk("pin_multi_lo", mr, 8'h00);
      run(7'h01, 0);
      model(7'h02, mr, me, mc);
      chk("pin_multi_hi", mr, 8'h08);
      run(7'h02, 0);

      load_xor();
      model(7'h00, mr, me, mc);
      chk("pin_clear_res", mr, 8'h00);
      run(7'h00, 0);
      for (int k = 0; k < 3; k++) run(7'($urandom), 1);

      for (int i = 0; i < 64; i++) wr(i, mk(2'b10, 10, 0, 0));
      model(7'h3C, mr, me, mc);
      chk("pin_ovr_err", me, 1);
      chk("pin_ovr_exec", mc, 129);
      run(7'h3C, 1);

      for (int k = 0; k < 20; k++) begin
         len = $urandom_range(0, 20);
         for (int i = 0; i < len; i++) begin
            wr(i, mk(2'($urandom_range(1, 3)), $urandom_range(0, 63),
                     $urandom_range(0, 63), $urandom_range(0, 63)));
         end
         wr(len, 20'h0);
         run(7'($urandom), 1'($urandom_range(0, 1)));
      end

      load_xor();
      @(negedge clk);
      prog_we = 1'b0;
      start = 1'b1;
      in_vec = 7'h03;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < 64; i++) tb_mem[i] = '0;
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      chk("midrst_err", err, 0);
      chk("midrst_result", result, 0);
      chk("midrst_exec", exec_cycles, 0);
      chk("midrst_cells", 32'(dut.u_cells.cells_q != 64'h0), 0);
      nz = 0;
      for (int i = 0; i < 64; i++) begin
         mw = dut.mem_q[i];
         if (mw != 20'h0) nz++;
      end
      chk("midrst_mem_end", nz, 0);
      @(negedge clk);
      rst_n = 1'b1;
      run(7'h2A, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
